dm_lsu_mem: RTL

- Byte-addressed, little-endian data memory for the single-cycle/multicycle MIPS datapath.
- Supports word, halfword and byte loads (signed and unsigned) and word, halfword and byte stores through a valid/ready request channel.
- Configurable response latency, misalignment detection, and a sticky error record for the control unit / exception logic.
- Sits between the EX/MEM stage and the memory array.

---
 rtl/dm_lsu_mem.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dm_lsu_mem.sv
// Byte-addressed little-endian data memory for the MIPS datapath: valid/ready request,
// fixed response latency, misalignment detection and a sticky first-error record.
//   state | meaning
//   IDLE  | ready=1, waiting for a request
//   WAIT  | request accepted, latency countdown running
//   RESP  | one-cycle resp_valid pulse
module dm_lsu_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  err_flag,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr
);
  localparam int         MEM_BYTES = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           pend_rdata_q, pend_rdata_d;
  logic                  pend_err_q, pend_err_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // 2-state storage: contents start at zero and are deliberately outside rst_n.
  bit [7:0] mem_q [MEM_BYTES];

  logic                  accept, misaligned, wr_en, enter_resp;
  logic [3:0]            byte_en;
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [7:0]            rd_byte [4];
  logic [31:0]           load_val, acc_rdata, src_rdata;
  logic                  src_err;
  logic [ADDR_WIDTH-1:0] src_addr;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = req_addr + ADDR_WIDTH'(k);
      rd_byte[k]   = mem_q[lane_addr[k]];
    end
  end

  always_comb begin
    misaligned = 1'b1;
    byte_en    = 4'b0000;
    load_val   = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    case (req_size)
      2'b00: begin
        misaligned = 1'b0;
        byte_en    = 4'b0001;
        load_val   = {{24{~req_unsigned & rd_byte[0][7]}}, rd_byte[0]};
      end
      2'b01: begin
        misaligned = req_addr[0];
        byte_en    = 4'b0011;
        load_val   = {{16{~req_unsigned & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    accept    = req_valid && (state_q == IDLE);
    wr_en     = accept && req_we && !misaligned;
    acc_rdata = (req_we || misaligned) ? 32'd0 : load_val;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem_q[lane_addr[k]] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      pend_addr_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      pend_addr_q  <= pend_addr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      err_flag_q   <= err_flag_d;
      err_addr_q   <= err_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    pend_addr_d  = pend_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = (LATENCY > 1) ? WAIT : RESP;
          cnt_d        = CNT_LOAD;
          pend_rdata_d = acc_rdata;
          pend_err_d   = misaligned;
          pend_addr_d  = req_addr;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // With LATENCY=1 the response is loaded straight from the accepting request.
    enter_resp   = (state_d == RESP) && (state_q != RESP);
    src_rdata    = accept ? acc_rdata : pend_rdata_q;
    src_err      = accept ? misaligned : pend_err_q;
    src_addr     = accept ? req_addr : pend_addr_q;
    resp_rdata_d = enter_resp ? src_rdata : resp_rdata_q;
    resp_err_d   = enter_resp ? src_err : resp_err_q;

    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end else if (enter_resp && src_err) begin
      err_flag_d = 1'b1;
      if (!err_flag_q) err_addr_d = src_addr;
    end
  end

  always_comb begin
    ready      = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign err_flag   = err_flag_q;
  assign err_addr   = err_addr_q;

endmodule
